alu_md_unit: RTL and testbench

Parametrised successor to the single-cycle ALU. It keeps a combinational ALU path and adds a multi-cycle multiply/divide engine with HI/LO registers and a busy handshake. It sits in the EX stage of the pipelined CPU: the hazard unit stalls on `busy`, and the `mfhi`/`mflo` instructions read `hi`/`lo` directly.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/md_core.sv | 205 ++++++++++++++++++++
 rtl/alu_md_unit.sv | 74 +++++++
 tb/tb_alu_md_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide unit: ALU opcodes,
// multiply/divide opcodes and the engine state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_core.sv
// Multi-cycle multiply/divide engine with HI/LO registers and busy handshake.
// Divider is built only when ALU_MD_DIV_EN is defined.
module md_core
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       md_op,
    input  logic             md_start,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    md_state_e           state_r;
    md_state_e           state_nx_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic [WIDTH-1:0]    hi_r;
    logic [WIDTH-1:0]    lo_r;
    logic [WIDTH-1:0]    pend_hi_r;
    logic [WIDTH-1:0]    pend_lo_r;
    logic                pend_wr_r;

    logic                is_mul_s;
    logic [2*WIDTH-1:0]  a_ext_s;
    logic [2*WIDTH-1:0]  b_ext_s;
    logic [2*WIDTH-1:0]  prod_s;
    logic [WIDTH-1:0]    pend_hi_s;
    logic [WIDTH-1:0]    pend_lo_s;
    logic                pend_wr_s;
    logic [CNT_W-1:0]    load_cnt_s;
    logic                start_s;
    logic                commit_s;
    logic                wr_hi_s;
    logic                wr_lo_s;

`ifdef ALU_MD_DIV_EN
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             neg_a_s;
    logic             neg_b_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH-1:0] mag_q_s;
    logic [WIDTH-1:0] mag_r_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    // Sign-magnitude divide: truncating quotient, remainder follows the dividend.
    always_comb begin
        neg_a_s = (md_op == MD_DIV) && a[WIDTH-1];
        neg_b_s = (md_op == MD_DIV) && b[WIDTH-1];
        mag_a_s = neg_a_s ? (~a + ONE_W) : a;
        mag_b_s = neg_b_s ? (~b + ONE_W) : b;
        if (mag_b_s == ZERO_W) begin
            mag_q_s = ZERO_W;
            mag_r_s = ZERO_W;
        end else begin
            mag_q_s = mag_a_s / mag_b_s;
            mag_r_s = mag_a_s % mag_b_s;
        end
        quo_s = (neg_a_s ^ neg_b_s) ? (~mag_q_s + ONE_W) : mag_q_s;
        rem_s = neg_a_s ? (~mag_r_s + ONE_W) : mag_r_s;
    end
`endif

    // Full result, write-enable and busy length for the operation being started.
    always_comb begin
        is_mul_s = (md_op == MD_MULT) || (md_op == MD_MULTU);
        if (md_op == MD_MULT) begin
            a_ext_s = {{WIDTH{a[WIDTH-1]}}, a};
            b_ext_s = {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            a_ext_s = {{WIDTH{1'b0}}, a};
            b_ext_s = {{WIDTH{1'b0}}, b};
        end
        prod_s = a_ext_s * b_ext_s;
        if (is_mul_s) begin
            pend_hi_s  = prod_s[2*WIDTH-1:WIDTH];
            pend_lo_s  = prod_s[WIDTH-1:0];
            pend_wr_s  = 1'b1;
            load_cnt_s = MULT_CNT;
        end else begin
`ifdef ALU_MD_DIV_EN
            pend_hi_s  = rem_s;
            pend_lo_s  = quo_s;
            pend_wr_s  = (b != ZERO_W);
            load_cnt_s = DIV_CNT;
`else
            pend_hi_s  = ZERO_W;
            pend_lo_s  = ZERO_W;
            pend_wr_s  = 1'b0;
            load_cnt_s = CNT_ONE;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (md_start) begin
                    state_nx_s = MD_RUN;
                end else begin
                    state_nx_s = MD_IDLE;
                end
            end
            MD_RUN: begin
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = MD_IDLE;
                end else begin
                    state_nx_s = MD_RUN;
                end
            end
            default: state_nx_s = MD_IDLE;
        endcase
    end

    // Per-state control strobes; requests seen in RUN are dropped.
    always_comb begin
        start_s  = 1'b0;
        commit_s = 1'b0;
        wr_hi_s  = 1'b0;
        wr_lo_s  = 1'b0;
        case (state_r)
            MD_IDLE: begin
                start_s = md_start;
                wr_hi_s = mthi && !md_start;
                wr_lo_s = mtlo && !md_start;
            end
            MD_RUN: begin
                commit_s = (cnt_r == CNT_ONE);
            end
            default: begin
                start_s  = 1'b0;
                commit_s = 1'b0;
            end
        endcase
    end

    // Counter, pending result, busy flag and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
            pend_hi_r <= ZERO_W;
            pend_lo_r <= ZERO_W;
            pend_wr_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s == MD_RUN);
            if (start_s) begin
                cnt_r     <= load_cnt_s;
                pend_hi_r <= pend_hi_s;
                pend_lo_r <= pend_lo_s;
                pend_wr_r <= pend_wr_s;
            end else if (state_r == MD_RUN) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
            if (commit_s && pend_wr_r) begin
                hi_r <= pend_hi_r;
                lo_r <= pend_lo_r;
            end else begin
                if (wr_hi_s) begin
                    hi_r <= a;
                end
                if (wr_lo_s) begin
                    lo_r <= a;
                end
            end
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: rtl/alu_md_unit.sv
// EX-stage ALU (combinational) plus multi-cycle multiply/divide engine.
// Optional divider enabled by defining ALU_MD_DIV_EN.
module alu_md_unit
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic [WIDTH-1:0] result,
    output logic             Zero,
    input  logic [1:0]       md_op,
    input  logic             md_start,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  shamt_s;
    logic [WIDTH-1:0] result_s;

    assign shamt_s = A[SH_W-1:0];

    // ALU operation mux; unused codes yield zero.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        case (ALUop)
            ALU_ADD:  result_s = A + B;
            ALU_SUB:  result_s = A - B;
            ALU_OR:   result_s = A | B;
            ALU_AND:  result_s = A & B;
            ALU_XOR:  result_s = A ^ B;
            ALU_NOR:  result_s = ~(A | B);
            ALU_SLT:  result_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: result_s = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:  result_s = B << shamt_s;
            ALU_SRL:  result_s = B >> shamt_s;
            ALU_SRA:  result_s = $unsigned($signed(B) >>> shamt_s);
            ALU_LUI:  result_s = B << (WIDTH / 2);
            default:  result_s = {WIDTH{1'b0}};
        endcase
    end

    assign result = result_s;
    assign Zero   = (A == B);

    md_core #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_core (
        .clk      (clk),
        .reset    (reset),
        .a        (A),
        .b        (B),
        .md_op    (md_op),
        .md_start (md_start),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit: directed cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_alu_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  ALUop;
    logic [31:0] result;
    logic        Zero;
    logic [1:0]  md_op;
    logic        md_start, mthi, mtlo;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

`ifdef ALU_MD_DIV_EN
    localparam int DIV_N = 10;
`else
    localparam int DIV_N = 1;
`endif

    // reference model state
    logic [31:0] hi_m = 32'h0, lo_m = 32'h0;
    bit          busy_m = 1'b0;
    int          edge_cnt = 0;
    int          done_edge = 0;
    logic [31:0] pend_hi_m, pend_lo_m;
    bit          pend_wr_m;

    alu_md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .ALUop(ALUop),
        .result(result), .Zero(Zero), .md_op(md_op), .md_start(md_start),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic signed [63:0] sb;
        int sh;
        sh = int'(a[4:0]);
        sb = {{32{b[31]}}, b};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a | b;
            4'd3:  return a & b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << sh;
            4'd9:  return b >> sh;
            4'd10: return 32'(sb >>> sh);
            4'd11: return {b[15:0], 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs held during the cycle.
    task automatic model_step();
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up;
        edge_cnt++;
        if (reset) begin
            hi_m = 32'h0; lo_m = 32'h0; busy_m = 1'b0;
        end else if (busy_m) begin
            if (edge_cnt == done_edge) begin
                busy_m = 1'b0;
                if (pend_wr_m) begin
                    hi_m = pend_hi_m; lo_m = pend_lo_m;
                end
            end
        end else if (md_start) begin
            sa = {{32{A[31]}}, A}; sb = {{32{B[31]}}, B};
            ua = {32'h0, A};       ub = {32'h0, B};
            busy_m = 1'b1;
            pend_wr_m = 1'b1;
            pend_hi_m = 32'h0; pend_lo_m = 32'h0;
            case (md_op)
                2'd0: begin sp = sa * sb; {pend_hi_m, pend_lo_m} = sp; done_edge = edge_cnt + 5; end
                2'd1: begin up = ua * ub; {pend_hi_m, pend_lo_m} = up; done_edge = edge_cnt + 5; end
                default: begin
                    done_edge = edge_cnt + DIV_N;
`ifdef ALU_MD_DIV_EN
                    if (B == 32'h0) begin
                        pend_wr_m = 1'b0;
                    end else if (md_op == 2'd2) begin
                        sq = sa / sb; sr = sa % sb;
                        pend_lo_m = sq[31:0]; pend_hi_m = sr[31:0];
                    end else begin
                        pend_lo_m = 32'(ua / ub); pend_hi_m = 32'(ua % ub);
                    end
`else
                    pend_wr_m = 1'b0;
`endif
                end
            endcase
        end else begin
            if (mthi) hi_m = A;
            if (mtlo) lo_m = A;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", {31'h0, busy}, {31'h0, busy_m});
            chk("hi", hi, hi_m);
            chk("lo", lo, lo_m);
            chk("result", result, alu_ref(A, B, ALUop));
            chk("zero", {31'h0, Zero}, {31'h0, (A == B)});
        end
    end

    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        A = a; B = b; md_op = op; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic alu_lit(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] exp, input string name);
        A = a; B = b; ALUop = op;
        tick();
        chk(name, result, exp);
    endtask

    initial begin
        int n;
        reset = 1'b1; A = 32'h0; B = 32'h0; ALUop = 4'd0;
        md_op = 2'd0; md_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        #2;
        tick(); tick();
        reset = 1'b0;
        check_en = 1'b1;
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        alu_lit(32'hFFFFFFFF, 32'h1, 4'd0, 32'h0, "alu_add");
        alu_lit(32'hFFFFFFFF, 32'h1, 4'd1, 32'hFFFFFFFE, "alu_sub");
        alu_lit(32'hFFFFFFFF, 32'h1, 4'd6, 32'h1, "alu_slt");
        alu_lit(32'hFFFFFFFF, 32'h1, 4'd7, 32'h0, "alu_sltu");
        alu_lit(32'h4, 32'h80000000, 4'd10, 32'hF8000000, "alu_sra");
        alu_lit(32'h4, 32'h80000000, 4'd13, 32'h0, "alu_op13");
        alu_lit(32'h0, 32'h00001234, 4'd11, 32'h12340000, "alu_lui");

        run_md(2'd0, 32'hFFFFFFFE, 32'h3, n);
        chk("mult_cycles", n, 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        run_md(2'd1, 32'hFFFFFFFE, 32'h3, n);
        chk("multu_cycles", n, 32'd5);
        chk("multu_hi", hi, 32'h2);
        chk("multu_lo", lo, 32'hFFFFFFFA);

        run_md(2'd2, 32'hFFFFFFF9, 32'h2, n);
        chk("div_cycles", n, DIV_N);
`ifdef ALU_MD_DIV_EN
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_lo", lo, 32'hFFFFFFFD);
`else
        chk("div_off_hi", hi, 32'h2);
        chk("div_off_lo", lo, 32'hFFFFFFFA);
`endif

        A = 32'h11; mthi = 1'b1; tick(); mthi = 1'b0;
        A = 32'h22; mtlo = 1'b1; tick(); mtlo = 1'b0;
        chk("mthi", hi, 32'h11);
        chk("mtlo", lo, 32'h22);
        run_md(2'd2, 32'h64, 32'h0, n);
        chk("div0_cycles", n, DIV_N);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        run_md(2'd3, 32'd10, 32'd3, n);
        chk("divu_cycles", n, DIV_N);
`ifdef ALU_MD_DIV_EN
        chk("divu_hi", hi, 32'h1);
        chk("divu_lo", lo, 32'h3);
`else
        chk("divu_off_hi", hi, 32'h11);
        chk("divu_off_lo", lo, 32'h22);
`endif

        A = 32'h77; mthi = 1'b1; mtlo = 1'b1; tick(); mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", hi, 32'h77);
        chk("mt_both_lo", lo, 32'h77);

        // start wins over a simultaneous mthi/mtlo
        A = 32'd9; B = 32'd9; md_op = 2'd0; md_start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        tick();
        md_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin n++; tick(); end
        chk("start_wins_hi", hi, 32'h0);
        chk("start_wins_lo", lo, 32'd81);

        // requests during a multiply are dropped
        A = 32'd5; B = 32'd7; md_op = 2'd0; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        n = 1;
        tick();
        A = 32'hDEAD; B = 32'd3; md_op = 2'd3; md_start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        n++;
        tick();
        md_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        while (busy === 1'b1 && n < 64) begin n++; tick(); end
        chk("ignored_cycles", n, 32'd5);
        chk("ignored_hi", hi, 32'h0);
        chk("ignored_lo", lo, 32'd35);
        // first cycle with busy low accepts a new start
        A = 32'd6; B = 32'd7; md_op = 2'd1; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        chk("b2b_busy", {31'h0, busy}, 32'h1);
        n = 0;
        while (busy === 1'b1 && n < 64) begin n++; tick(); end
        chk("b2b_lo", lo, 32'd42);

        // reset during cycle 3 of a divide
        A = 32'h55; mthi = 1'b1; tick(); mthi = 1'b0;
        A = 32'h66; mtlo = 1'b1; tick(); mtlo = 1'b0;
        A = 32'd100; B = 32'd7; md_op = 2'd2; md_start = 1'b1;
        tick();
        md_start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        chk("rst_no_commit_hi", hi, 32'h0);
        chk("rst_no_commit_lo", lo, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0: begin A = 32'h80000000; B = 32'hFFFFFFFF; end
                1: begin A = $urandom; B = 32'h0; end
                2: begin A = $urandom_range(0, 40); B = $urandom_range(0, 9); end
                default: begin A = $urandom; B = $urandom; end
            endcase
            ALUop    = 4'($urandom_range(0, 15));
            md_op    = 2'($urandom_range(0, 3));
            md_start = ($urandom_range(0, 3) == 0);
            mthi     = ($urandom_range(0, 3) == 0);
            mtlo     = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; md_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
